// File: rtl/dac_i2s_transmitter.sv
// I2S transmitter for a stereo DAC: 2-entry {L,R} FIFO feeding a Philips I2S serializer.
// Optional build macro DAC_TX_UNDERRUN_REPEAT_EN repeats the last pair on underrun.
module dac_i2s_transmitter #(
  parameter int BCLK_HALF = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        audio_valid,
  input  logic [15:0] dac_in_l,
  input  logic [15:0] dac_in_r,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic [1:0]  fifo_level,
  output logic        underrun,
  output logic        overrun
);

  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CW-1:0] HMAX = CW'(BCLK_HALF - 1);

  logic [CW-1:0] half_cnt;
  logic [4:0]    b;
  logic [4:0]    nb;
  logic [31:0]   sh;
  logic          r0;
  logic [31:0]   mem [2];
  logic          wp;
  logic          rp;
  logic          tick;
  logic          fall;
  logic          fs;
  logic          pop;
  logic          push;
  logic [31:0]   head;
  logic [31:0]   fallback;
  logic [31:0]   next_pair;

  assign tick      = (half_cnt == HMAX);
  assign fall      = tick && i2s_bclk;
  assign fs        = fall && (b == 5'd31);
  assign pop       = fs && (fifo_level != 2'd0);
  assign push      = audio_valid && ((fifo_level != 2'd2) || pop);
  assign head      = mem[rp];
  assign nb        = b + 5'd1;
  assign next_pair = pop ? head : fallback;

`ifdef DAC_TX_UNDERRUN_REPEAT_EN
  logic [31:0] last;

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= '0;
    end else if (pop) begin
      last <= head;
    end
  end

  assign fallback = last;
`else
  assign fallback = '0;
`endif

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= {dac_in_l, dac_in_r};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      half_cnt   <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      b          <= 5'd31;
      sh         <= '0;
      r0         <= 1'b0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      fifo_level <= 2'd0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      half_cnt <= tick ? '0 : half_cnt + CW'(1);
      underrun <= fs && !pop;
      overrun  <= audio_valid && !push;
      if (tick) begin
        i2s_bclk <= ~i2s_bclk;
      end
      if (fall) begin
        b         <= nb;
        i2s_lrclk <= nb[4];
        // Slot 0 carries the previous frame's R[0] (one-bit delay).
        if (fs) begin
          i2s_sdata <= r0;
          sh        <= next_pair;
          r0        <= next_pair[0];
        end else begin
          i2s_sdata <= sh[31];
          sh        <= {sh[30:0], 1'b0};
        end
      end
      if (push) begin
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      fifo_level <= fifo_level + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dac_i2s_transmitter.sv
// Self-checking bench for dac_i2s_transmitter (BCLK_HALF=1 and 3 instances).
// Frame-level reference model plus a directed vector table and corner sequences.
module tb_dac_i2s_transmitter;

  logic        clock = 1'b0;
  logic        reset;
  logic        audio_valid;
  logic [15:0] dac_in_l;
  logic [15:0] dac_in_r;

  logic       bclk1, lr1, sd1, un1, ov1;
  logic [1:0] lev1;
  logic       bclk3, lr3, sd3, un3, ov3;
  logic [1:0] lev3;

  always #5 clock = ~clock;

  dac_i2s_transmitter #(.BCLK_HALF(1)) u_dut1 (
    .clock(clock), .reset(reset), .audio_valid(audio_valid),
    .dac_in_l(dac_in_l), .dac_in_r(dac_in_r),
    .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1),
    .fifo_level(lev1), .underrun(un1), .overrun(ov1)
  );

  dac_i2s_transmitter #(.BCLK_HALF(3)) u_dut3 (
    .clock(clock), .reset(reset), .audio_valid(audio_valid),
    .dac_in_l(dac_in_l), .dac_in_r(dac_in_r),
    .i2s_bclk(bclk3), .i2s_lrclk(lr3), .i2s_sdata(sd3),
    .fifo_level(lev3), .underrun(un3), .overrun(ov3)
  );

`ifdef DAC_TX_UNDERRUN_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clocks since reset, a list of buffered pairs,
  // and the pair currently on the wire.
  int          mk [2];
  logic [31:0] mq [2][3];
  int          mn [2];
  logic [31:0] mcur [2];
  logic        mr0 [2];
  logic [31:0] mlast [2];
  logic        e_bclk [2];
  logic        e_lr [2];
  logic        e_sd [2];
  logic        e_un [2];
  logic        e_ov [2];
  int          e_lev [2];

  task automatic model_edge(int i, logic rst, logic v, logic [31:0] w);
    int bh, t, n, b;
    bit fs, pop;
    bh = (i == 0) ? 1 : 3;
    if (rst) begin
      mk[i] = 0; mn[i] = 0; mcur[i] = 0; mr0[i] = 0; mlast[i] = 0;
      e_bclk[i] = 0; e_lr[i] = 0; e_sd[i] = 0;
      e_un[i] = 0; e_ov[i] = 0; e_lev[i] = 0;
      return;
    end
    mk[i]++;
    t = mk[i] / bh;
    n = t / 2;
    fs = (mk[i] % bh == 0) && (t % 2 == 0) && (n % 32 == 1);
    pop = fs && (mn[i] > 0);
    e_un[i] = fs && (mn[i] == 0);
    e_ov[i] = v && (mn[i] == 2) && !pop;
    if (fs) begin
      mr0[i] = mcur[i][0];
      if (pop) begin
        mcur[i] = mq[i][0];
        mq[i][0] = mq[i][1];
        mn[i]--;
        mlast[i] = mcur[i];
      end else begin
        mcur[i] = REP ? mlast[i] : 32'd0;
      end
    end
    if (v && !e_ov[i]) begin
      mq[i][mn[i]] = w;
      mn[i]++;
    end
    e_bclk[i] = (t % 2 == 1);
    if (n == 0) begin
      e_lr[i] = 0;
      e_sd[i] = 0;
    end else begin
      b = (n - 1) % 32;
      e_lr[i] = (b >= 16);
      e_sd[i] = (b == 0) ? mr0[i] : mcur[i][32 - b];
    end
    e_lev[i] = mn[i];
  endtask

  logic p_bclk3, p_lr3, p_sd3;

  task automatic step(logic rst, logic v, logic [15:0] l, logic [15:0] r);
    reset = rst;
    audio_valid = v;
    dac_in_l = l;
    dac_in_r = r;
    @(posedge clock);
    #1;
    model_edge(0, rst, v, {l, r});
    model_edge(1, rst, v, {l, r});
    chk("bclk1", bclk1, e_bclk[0]);
    chk("lrclk1", lr1, e_lr[0]);
    chk("sdata1", sd1, e_sd[0]);
    chk("level1", lev1, e_lev[0]);
    chk("underrun1", un1, e_un[0]);
    chk("overrun1", ov1, e_ov[0]);
    chk("bclk3", bclk3, e_bclk[1]);
    chk("lrclk3", lr3, e_lr[1]);
    chk("sdata3", sd3, e_sd[1]);
    chk("level3", lev3, e_lev[1]);
    chk("underrun3", un3, e_un[1]);
    chk("overrun3", ov3, e_ov[1]);
    if (!rst && ((sd3 !== p_sd3) || (lr3 !== p_lr3)))
      chk("data_edge3", {p_bclk3, bclk3}, 2'b10);
    p_bclk3 = bclk3;
    p_lr3 = lr3;
    p_sd3 = sd3;
    audio_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  typedef struct {
    int          cyc;
    logic        v;
    logic [15:0] l;
    logic [15:0] r;
    logic        lr;
    logic        sd;
    logic [1:0]  lev;
    logic        un;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int idx;
    int cnt1, cnt3, ones, rise3, pos3a, pos3b;
    logic pb;
    reset = 1'b1;
    audio_valid = 1'b0;
    dac_in_l = '0;
    dac_in_r = '0;
    p_bclk3 = 0; p_lr3 = 0; p_sd3 = 0;

    tbl[0]  = '{1,  1, 16'hA5C3, 16'h0F01, 0, 0, 1, 0};
    tbl[1]  = '{2,  0, 16'h0,    16'h0,    0, 0, 0, 0};
    tbl[2]  = '{4,  0, 16'h0,    16'h0,    0, 1, 0, 0};
    tbl[3]  = '{6,  0, 16'h0,    16'h0,    0, 0, 0, 0};
    tbl[4]  = '{8,  0, 16'h0,    16'h0,    0, 1, 0, 0};
    tbl[5]  = '{12, 0, 16'h0,    16'h0,    0, 0, 0, 0};
    tbl[6]  = '{14, 0, 16'h0,    16'h0,    0, 1, 0, 0};
    tbl[7]  = '{32, 0, 16'h0,    16'h0,    0, 1, 0, 0};
    tbl[8]  = '{34, 0, 16'h0,    16'h0,    1, 1, 0, 0};
    tbl[9]  = '{36, 0, 16'h0,    16'h0,    1, 0, 0, 0};
    tbl[10] = '{44, 0, 16'h0,    16'h0,    1, 1, 0, 0};
    tbl[11] = '{64, 0, 16'h0,    16'h0,    1, 0, 0, 0};
    tbl[12] = '{66, 0, 16'h0,    16'h0,    0, 1, 0, 1};
    tbl[13] = '{68, 0, 16'h0,    16'h0,    0, REP, 0, 0};

    // Reset state
    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    chk("rst_bclk", bclk1, 0);
    chk("rst_sdata", sd1, 0);
    chk("rst_level", lev1, 0);

    // Basic frame from the vector table
    idx = 0;
    for (int k = 1; k <= 68; k++) begin
      bit hit;
      hit = (idx < 14) && (tbl[idx].cyc == k);
      if (hit) step(1'b0, tbl[idx].v, tbl[idx].l, tbl[idx].r);
      else idle();
      if (hit) begin
        chk("tbl_lrclk", lr1, tbl[idx].lr);
        chk("tbl_sdata", sd1, tbl[idx].sd);
        chk("tbl_level", lev1, tbl[idx].lev);
        chk("tbl_underrun", un1, tbl[idx].un);
        idx++;
      end
    end

    // Continuous underrun and divider timing
    step(1'b1, 1'b0, 16'h0, 16'h0);
    cnt1 = 0; cnt3 = 0; ones = 0; rise3 = 0; pos3a = 0; pos3b = 0;
    pb = bclk3;
    for (int k = 1; k <= 400; k++) begin
      idle();
      if (un1) cnt1++;
      if (sd1 || sd3) ones++;
      if (un3) begin
        cnt3++;
        if (cnt3 == 1) pos3a = k;
        if (cnt3 == 2) pos3b = k;
      end
      if (k <= 192 && bclk3 && !pb) rise3++;
      pb = bclk3;
    end
    chk("underrun_cnt1", cnt1, 7);
    chk("underrun_cnt3", cnt3, 3);
    chk("underrun_sdata", ones, 0);
    chk("div_first_frame", pos3a, 6);
    chk("div_frame_len", pos3b - pos3a, 192);
    chk("div_bclk_rises", rise3, 32);

    // Single pair, then starve: repeat vs zero fallback
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 80; k++) begin
      if (k == 1) step(1'b0, 1'b1, 16'h1234, 16'h5678);
      else idle();
      if (k == 10) chk("rep_first_l12", sd1, 1);
      if (k == 66) chk("rep_underrun", un1, 1);
      if (k == 74) chk("rep_second_l12", sd1, REP);
    end

    // Overrun: three back-to-back pushes
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 140; k++) begin
      if (k == 3) step(1'b0, 1'b1, 16'h8000, 16'h0001);
      else if (k == 4) step(1'b0, 1'b1, 16'h7FFF, 16'h0002);
      else if (k == 5) step(1'b0, 1'b1, 16'hFFFF, 16'h0003);
      else idle();
      if (k == 3) chk("ovr_level_a", lev1, 1);
      if (k == 4) chk("ovr_level_b", lev1, 2);
      if (k == 4) chk("ovr_none_b", ov1, 0);
      if (k == 5) chk("ovr_level_c", lev1, 2);
      if (k == 5) chk("ovr_pulse", ov1, 1);
      if (k == 6) chk("ovr_once", ov1, 0);
      if (k == 68) chk("ovr_first", sd1, 1);
      if (k == 132) chk("ovr_second", sd1, 0);
      if (k == 130) chk("ovr_drained", lev1, 0);
    end

    // Push coinciding with a pop while full
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 200; k++) begin
      if (k == 3) step(1'b0, 1'b1, 16'h8000, 16'h1111);
      else if (k == 4) step(1'b0, 1'b1, 16'h0000, 16'h2222);
      else if (k == 66) step(1'b0, 1'b1, 16'hFFFF, 16'h3333);
      else idle();
      if (k == 66) chk("pp_no_overrun", ov1, 0);
      if (k == 66) chk("pp_level", lev1, 2);
      if (k == 68) chk("pp_order_a", sd1, 1);
      if (k == 132) chk("pp_order_b", sd1, 0);
      if (k == 196) chk("pp_order_c", sd1, 1);
    end

    // Reset in the middle of a frame (b=20)
    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    for (int k = 2; k <= 42; k++) idle();
    chk("mid_lrclk_b20", lr1, 1);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    chk("mid_bclk", bclk1, 0);
    chk("mid_lrclk", lr1, 0);
    chk("mid_sdata", sd1, 0);
    chk("mid_level", lev1, 0);
    chk("mid_flags", {un1, ov1}, 0);
    idle();
    chk("mid_rise", bclk1, 1);
    idle();
    chk("mid_fall", bclk1, 0);
    chk("mid_frame_start", un1, 1);
    chk("mid_r0", sd1, 0);

    // Randomized traffic: fast then slow producer, rare resets
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 3000; k++) begin
      int lim;
      lim = (k < 1500) ? 39 : 149;
      if ($urandom_range(0, 999) == 0)
        step(1'b1, 1'b0, 16'h0, 16'h0);
      else
        step(1'b0, $urandom_range(0, lim) == 0,
             16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_i2s_transmitter.md
# dac_i2s_transmitter

Consumer end of the DSP audio output interface. Accepts 16-bit stereo sample pairs on an `audio_valid` strobe and buffers them in a 2-entry FIFO. Serializes them as a standard Philips I2S stream (BCLK, LRCLK, SDATA) toward an external DAC codec. Sits between the DSP core and the board audio pins, decoupling the DSP sample strobe from the I2S frame timing.

## Interface

**Parameters**

- `BCLK_HALF`, default 1: system clocks per half BCLK period; must be ≥1.
- `SLOT_BITS`, fixed 16: bits per channel slot. One frame is 32 BCLK periods, i.e. 64·BCLK_HALF clocks.

**Ports**

- `clock` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `audio_valid` input 1: one-cycle strobe; `dac_in_l`/`dac_in_r` are valid this cycle.
- `dac_in_l` input 16: left sample, two's complement.
- `dac_in_r` input 16: right sample, two's complement.
- `i2s_bclk` output 1: bit clock, registered.
- `i2s_lrclk` output 1: word select; 0 = left, 1 = right; registered.
- `i2s_sdata` output 1: serial data, MSB first; registered.
- `fifo_level` output 2: number of buffered pairs, 0..2.
- `underrun` output 1: one-cycle pulse when a frame starts with the FIFO empty.
- `overrun` output 1: one-cycle pulse when a push is dropped.

## Operation

**Clock divider**
- `half_cnt` counts 0..BCLK_HALF-1. On wrap, `i2s_bclk` toggles.
- A falling BCLK edge (register going 1→0) is the only event that advances the bit slot counter `b` (0..31, wraps 31→0) and updates `i2s_lrclk`/`i2s_sdata`.

**Slot map (I2S one-bit delay)**
- b=0: `i2s_lrclk`=0, `i2s_sdata` = previous frame's R[0].
- b=1..15: `i2s_lrclk`=0, `i2s_sdata` = L[16-b], i.e. L[15] down to L[1].
- b=16: `i2s_lrclk`=1, `i2s_sdata` = L[0].
- b=17..31: `i2s_lrclk`=1, `i2s_sdata` = R[32-b], i.e. R[15] down to R[1].

**Frame start (entering b=0)**
- FIFO pops one pair into the shift register.
- If the FIFO is empty: pulse `underrun` and load the fallback pair (see Configuration).
- The previous R[0] is held in a 1-bit register.

**FIFO**
- 2 entries of {L,R}.
- Push on `audio_valid`.
- Push while full with no pop the same cycle: data dropped, `overrun` pulses, contents unchanged.
- Push and pop in the same cycle while full: both accepted, level stays 2.
- Push while empty in the same cycle as frame start: no bypass. The underrun is reported and the pushed pair is used next frame; level becomes 1.

**Arithmetic**
- Samples pass bit-exact; no scaling or sign handling.

## Timing

**Reset values** (one cycle after `reset` high)
- `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0.
- `b`=31, `half_cnt`=0, FIFO empty, `fifo_level`=0, held R[0]=0, last pair=0.
- `underrun`=0, `overrun`=0.

**Start-up and latency**
- The first falling BCLK occurs 2·BCLK_HALF clocks after reset deasserts and enters b=0 (first frame start).
- `fifo_level` updates the cycle after a push or pop.
- A pair pushed at least one clock before a frame start has its L[15] on `i2s_sdata` 2·BCLK_HALF clocks after that frame start.
- `i2s_lrclk` and `i2s_sdata` change only in the same cycle `i2s_bclk` goes 0. They are stable across the rising edge.

**Reset mid-frame**
- All state returns to the reset values in the next cycle.
- The partial frame is abandoned and buffered samples are discarded.
- No `underrun`/`overrun` pulse is generated by the reset itself.

## Configuration

- `DAC_TX_UNDERRUN_REPEAT_EN` defined: on underrun the last successfully popped pair is retransmitted (zero if none since reset).
- `DAC_TX_UNDERRUN_REPEAT_EN` undefined: on underrun the pair {0,0} is transmitted. The last-pair register is not built.
- The `underrun` pulse behaves identically in both builds.

## Test plan

- **Basic frame**, BCLK_HALF=1: push L=16'hA5C3, R=16'h0F01 at cycle 1 after reset.
  - Slots b=1..16 shift out A5C3 MSB-first with lrclk 0 (b=16 at lrclk 1).
  - b=17..31 shift out 0F01[15:1]; next frame's b=0 carries 1.
- **Underrun**: no pushes after reset.
  - `underrun` pulses at each frame start (every 64 clocks); `i2s_sdata` stays 0.
  - With the macro, after one pair 16'h1234/16'h5678 and no refill, the second frame repeats 1234/5678.
  - Without the macro, the second frame is all zeros.
- **Overrun**: three pushes on consecutive cycles before any frame start.
  - `fifo_level` goes 1, 2, 2; `overrun` pulses once on the third push.
  - The first two pairs are transmitted in order.
- **Simultaneous push/pop at full**: FIFO holds 2 pairs and a push coincides with a frame start.
  - No `overrun`; `fifo_level` stays 2; order is preserved.
- **Reset mid-frame**: assert `reset` at b=20 for one cycle.
  - Next cycle all outputs are 0 and `fifo_level`=0.
  - The first falling BCLK occurs 2 clocks after deassert with b=0.
- **Divider**: BCLK_HALF=3.
  - `i2s_bclk` period is 6 clocks and a frame is 192 clocks.
  - `i2s_sdata` transitions only coincide with `i2s_bclk` falling.
